controller_scanner: RTL

Parametrised serial game-controller scanner, successor to the two-port controller interface. It runs NES/SNES-style latch-and-shift reads on `NUM_CONTROLLERS` serial pads at a configurable word length and serial clock rate, then commits all pads atomically. It also tracks per-button "newly pressed" edges that firmware clears, and queues one fetch request that arrives while a scan is running. It sits beside the GPU, which drives `start_fetch_i` once per frame, and feeds the memory-mapped controller registers.

---
 rtl/controller_scanner_if.sv | 43 ++++
 rtl/controller_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/controller_scanner_if.sv
// Bundles the scanner's request/status, pad-side serial lines and the register-facing data words.
// Latency: none, wiring only; every output of the slave side is a registered signal of the scanner.
// Backpressure: none; requests are single-cycle strobes and the scanner queues at most one.
interface controller_scanner_if #(
  parameter int NUM_CONTROLLERS     = 2,
  parameter int BITS_PER_CONTROLLER = 8
);
  logic                                                   start_fetch_i;
  logic                                                   busy_o;
  logic                                                   done_o;
  logic                                                   clk_o;
  logic                                                   latch_o;
  logic [NUM_CONTROLLERS-1:0]                             serial_ni;
  logic [NUM_CONTROLLERS-1:0][BITS_PER_CONTROLLER-1:0]    data_o;
  logic [NUM_CONTROLLERS-1:0][BITS_PER_CONTROLLER-1:0]    pressed_o;
  logic [NUM_CONTROLLERS-1:0]                             clr_pressed_i;

  // System side: GPU frame strobe, firmware clears and the physical pads.
  modport master (
    output start_fetch_i,
    output serial_ni,
    output clr_pressed_i,
    input  busy_o,
    input  done_o,
    input  clk_o,
    input  latch_o,
    input  data_o,
    input  pressed_o
  );

  // Scanner side.
  modport slave (
    input  start_fetch_i,
    input  serial_ni,
    input  clr_pressed_i,
    output busy_o,
    output done_o,
    output clk_o,
    output latch_o,
    output data_o,
    output pressed_o
  );
endinterface

// File: rtl/controller_scanner.sv
// Latch-and-shift scanner for NUM_CONTROLLERS serial pads, committing all pad words together.
// Latency: 2*CLK_DIV*BITS_PER_CONTROLLER+1 cycles from the sampled request to done_o.
// Backpressure: one request arriving mid-scan is queued; further ones are dropped until it starts.
module controller_scanner #(
  parameter int NUM_CONTROLLERS     = 2,
  parameter int BITS_PER_CONTROLLER = 8,
  parameter int CLK_DIV             = 1
) (
  input  logic                clk,
  input  logic                rst,
  controller_scanner_if.slave bus
);

  localparam int N        = NUM_CONTROLLERS;
  localparam int BITS     = BITS_PER_CONTROLLER;
  localparam int CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW       = (BITS > 2) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_PENULT = KW'(BITS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_COMMIT
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        half_q, half_d;
  logic [KW-1:0]               k_q, k_d;
  logic                        pending_q;
  logic                        pending_clr;
  logic                        sample_en;
  logic                        commit;
  logic                        cnt_last;
  logic [N-1:0][BITS-1:0]      sh_q;
  logic [N-1:0][BITS-1:0]      data_q;
  logic [N-1:0][BITS-1:0]      pressed_q;

  assign cnt_last = (cnt_q == CNT_LAST);

  // State and sequencing counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      k_q     <= k_d;
    end
  end

  // Next state: the latch phase is two divider periods, tracked by half_q,
  // so the divider itself never has to count past CLK_DIV-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    k_d         = k_q;
    sample_en   = 1'b0;
    commit      = 1'b0;
    pending_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_fetch_i || pending_q) begin
          state_d     = S_LATCH;
          cnt_d       = '0;
          half_d      = 1'b0;
          k_d         = '0;
          pending_clr = 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (half_q) begin
            sample_en = 1'b1;
            state_d   = S_LOW;
          end else begin
            half_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_last) begin
          cnt_d     = '0;
          k_d       = k_q + 1'b1;
          sample_en = 1'b1;
          state_d   = (k_q == K_PENULT) ? S_COMMIT : S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One-deep request queue; a request in IDLE starts directly and is never queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else if (pending_clr) begin
      pending_q <= 1'b0;
    end else if (bus.start_fetch_i && (state_q != S_IDLE)) begin
      pending_q <= 1'b1;
    end
  end

  // Registered pad strobes and status, decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.latch_o <= 1'b0;
      bus.clk_o   <= 1'b1;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
    end else begin
      bus.latch_o <= (state_d == S_LATCH);
      bus.clk_o   <= (state_d != S_LOW);
      bus.busy_o  <= (state_d != S_IDLE);
      bus.done_o  <= commit;
    end
  end

  // Capture bit k_d of every pad; raw active-low levels are kept until commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else if (sample_en) begin
      for (int n = 0; n < N; n++) begin
        for (int b = 0; b < BITS; b++) begin
          if (k_d == KW'(b)) begin
            sh_q[n][b] <= bus.serial_ni[n];
          end
        end
      end
    end
  end

  // Atomic commit of all pads plus sticky newly-pressed flags; a clear on the
  // commit edge wipes only the old flags, never edges found by this scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      pressed_q <= '0;
    end else begin
      for (int n = 0; n < N; n++) begin
        if (commit) begin
          data_q[n]    <= ~sh_q[n];
          pressed_q[n] <= (pressed_q[n] & ~{BITS{bus.clr_pressed_i[n]}})
                        | (~sh_q[n] & ~data_q[n]);
        end else if (bus.clr_pressed_i[n]) begin
          pressed_q[n] <= '0;
        end
      end
    end
  end

  assign bus.data_o    = data_q;
  assign bus.pressed_o = pressed_q;

endmodule
